ram_burst_port: RTL and testbench

//  Burst initiator for one port of the shared 4-port RAM (address_n / data_write_n /
//  WR_signal_n / data_read_n). Turns a command (base, length, direction) into a run of

---
 rtl/ram_burst_port.sv | 140 ++++++++++++++
 tb/tb_ram_burst_port.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_port.sv
// Burst initiator for one port of the shared RAM: turns a (base, len, direction) command
// into consecutive RAM accesses, streaming reads out through a 2-entry skid FIFO.
module ram_burst_port #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12,
  parameter int LEN_WIDTH     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_last,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0]    data_write,
  output logic                     WR_signal,
  input  logic [DATA_WIDTH-1:0]    data_read
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state_reg, state_next;

  logic [ADDRESS_WIDTH-1:0] base_reg;
  logic [LEN_WIDTH-1:0]     len_reg;
  logic [LEN_WIDTH-1:0]     issue_cnt_reg;
  logic [LEN_WIDTH-1:0]     out_cnt_reg;
  logic [LEN_WIDTH-1:0]     acc_cnt_reg;
  logic                     inflight_reg;
  logic [DATA_WIDTH-1:0]    fifo_mem [0:1];
  logic                     wptr_reg, rptr_reg;
  logic [1:0]               fifo_count_reg;
  logic [ADDRESS_WIDTH-1:0] address_reg;
  logic [DATA_WIDTH-1:0]    data_write_reg;
  logic                     wr_signal_reg;

  logic       cmd_fire, rd_fire, wr_fire, issue;
  logic [2:0] occupancy;

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign rd_fire    = rd_valid && rd_ready;
  assign wr_fire    = wr_valid && wr_ready;
  assign rd_valid   = (fifo_count_reg != 2'd0);
  assign rd_data    = fifo_mem[rptr_reg];
  assign rd_last    = rd_valid && (out_cnt_reg == len_reg - LEN_WIDTH'(1));
  assign occupancy  = {1'b0, fifo_count_reg} + {2'b00, inflight_reg};
  assign address    = address_reg;
  assign data_write = data_write_reg;
  assign WR_signal  = wr_signal_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_fire) state_next = (cmd_len == '0) ? DONE : (cmd_write ? WR : RD);
      RD:      if (rd_fire && rd_last) state_next = DONE;
      WR:      if (acc_cnt_reg == len_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A pop this cycle frees a slot, so it counts as credit: that keeps full rate
  // while still guaranteeing every issued word has a FIFO slot when it lands.
  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    done      = 1'b0;
    issue     = 1'b0;
    case (state_reg)
      IDLE:    cmd_ready = 1'b1;
      RD:      issue = (issue_cnt_reg != len_reg) && (occupancy < 3'd2 + {2'b00, rd_fire});
      WR:      wr_ready = (acc_cnt_reg != len_reg);
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_reg       <= '0;
      len_reg        <= '0;
      issue_cnt_reg  <= '0;
      out_cnt_reg    <= '0;
      acc_cnt_reg    <= '0;
      inflight_reg   <= 1'b0;
      wptr_reg       <= 1'b0;
      rptr_reg       <= 1'b0;
      fifo_count_reg <= 2'd0;
      address_reg    <= '0;
      data_write_reg <= '0;
      wr_signal_reg  <= 1'b0;
    end else begin
      inflight_reg  <= issue;
      wr_signal_reg <= wr_fire;
      if (cmd_fire) begin
        base_reg      <= cmd_base;
        len_reg       <= cmd_len;
        issue_cnt_reg <= '0;
        out_cnt_reg   <= '0;
        acc_cnt_reg   <= '0;
        if (!cmd_write) address_reg <= cmd_base;
      end
      // Read: address_reg always shows the next candidate; it advances once consumed.
      if (issue) begin
        address_reg   <= address_reg + ADDRESS_WIDTH'(1);
        issue_cnt_reg <= issue_cnt_reg + LEN_WIDTH'(1);
      end
      if (wr_fire) begin
        address_reg    <= base_reg + ADDRESS_WIDTH'(acc_cnt_reg);
        data_write_reg <= wr_data;
        acc_cnt_reg    <= acc_cnt_reg + LEN_WIDTH'(1);
      end
      if (inflight_reg) wptr_reg <= ~wptr_reg;
      if (rd_fire) begin
        rptr_reg    <= ~rptr_reg;
        out_cnt_reg <= out_cnt_reg + LEN_WIDTH'(1);
      end
      fifo_count_reg <= fifo_count_reg + {1'b0, inflight_reg} - {1'b0, rd_fire};
    end
  end

  // Data_read belongs to the access issued last cycle.
  always_ff @(posedge clk) begin
    if (inflight_reg) fifo_mem[wptr_reg] <= data_read;
  end

endmodule

// File: tb/tb_ram_burst_port.sv
// Randomized bench for ram_burst_port: a RAM model on the port and a golden memory
// image updated from command semantics predict every write and every read word.
module tb_ram_burst_port;
  localparam int DW = 64, AW = 12, LW = 12, DEPTH = 1 << AW;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_base = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          rd_valid, rd_ready = 1'b0, rd_last;
  logic [DW-1:0] rd_data;
  logic          wr_valid = 1'b0, wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          done;
  logic [AW-1:0] address;
  logic [DW-1:0] data_write, data_read;
  logic          WR_signal;

  logic [DW-1:0] ram     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  int n_checks = 0, n_errors = 0;

  ram_burst_port #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .done(done),
    .address(address), .data_write(data_write), .WR_signal(WR_signal),
    .data_read(data_read)
  );

  always #5 clk = ~clk;

  // Shared RAM port: registered read of the sampled address, write when WR_signal.
  always @(posedge clk) begin
    data_read <= ram[address];
    if (WR_signal) ram[address] = data_write;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller in the first cycle after the accept edge.
  task automatic issue_cmd(input logic wr, input logic [AW-1:0] base, input int len);
    int guard = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_base = base; cmd_len = LW'(len);
    while (!cmd_ready && guard < 20) begin step(); guard++; end
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_base = AW'($urandom); cmd_len = LW'($urandom);
  endtask

  task automatic do_write(input logic [AW-1:0] base, input int len, input bit hold, input bit fixed);
    logic [DW-1:0] words[$];
    logic [AW-1:0] pend_addr = '0;
    logic [DW-1:0] pend_data = '0;
    bit pend = 0, beat;
    int sent = 0, bad = 0, done_cnt = 0, last_beat = -10, exp_done;
    for (int i = 0; i < len; i++)
      words.push_back(fixed ? 64'(i + 1) * 64'h1110_0000_0000_0000 : {$urandom, $urandom});
    issue_cmd(1'b1, base, len);
    for (int cyc = 1; cyc <= len * 8 + 10; cyc++) begin
      wr_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
      wr_data  = (sent < len) ? words[sent] : {$urandom, $urandom};
      rd_ready = 1'($urandom);
      if (wr_ready !== (sent < len)) bad++;
      if (WR_signal !== pend) bad++;
      if (rd_valid !== 1'b0) bad++;
      if (pend) begin
        check("wr_addr", 64'(address), 64'(pend_addr));
        check("wr_data", data_write, pend_data);
        ref_mem[pend_addr] = pend_data;
      end
      if (done) begin
        done_cnt++;
        exp_done = (len == 0) ? 1 : last_beat + 2;
        check("wr_done_cycle", 64'(cyc), 64'(exp_done));
        if (cmd_ready) bad++;
      end
      beat = wr_valid && (sent < len);
      if (beat) begin
        pend_addr = base + AW'(sent);
        pend_data = words[sent];
        sent++;
        last_beat = cyc;
      end
      pend = beat;
      if (done) break;
      step();
    end
    wr_valid = 1'b0;
    check("wr_beats", 64'(sent), 64'(len));
    check("wr_done_count", 64'(done_cnt), 64'd1);
    check("wr_protocol", 64'(bad), 64'd0);
    if (hold && len > 0) check("wr_back_to_back", 64'(last_beat), 64'(len));
    step();
  endtask

  task automatic do_read(input logic [AW-1:0] base, input int len, input int mode);
    logic [AW-1:0] a;
    logic [DW-1:0] prev_data = '0;
    bit prev_stall = 0;
    int got = 0, bad = 0, done_cnt = 0, first = -1, last_acc = -10, exp_done;
    issue_cmd(1'b0, base, len);
    for (int cyc = 1; cyc <= len * 8 + 12; cyc++) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 3 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = {$urandom, $urandom};
      if (WR_signal !== 1'b0 || wr_ready !== 1'b0) bad++;
      if (prev_stall && (rd_valid !== 1'b1 || rd_data !== prev_data)) bad++;
      if (rd_valid && first < 0) first = cyc;
      if (rd_valid && rd_ready) begin
        if (got < len) begin
          a = base + AW'(got);
          check("rd_data", rd_data, ref_mem[a]);
          check("rd_last", 64'(rd_last), 64'(got == len - 1));
        end else bad++;
        got++;
        last_acc = cyc;
      end
      if (done) begin
        done_cnt++;
        exp_done = (len == 0) ? 1 : last_acc + 1;
        check("rd_done_cycle", 64'(cyc), 64'(exp_done));
        if (cmd_ready) bad++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (done) break;
      step();
    end
    wr_valid = 1'b0;
    check("rd_words", 64'(got), 64'(len));
    check("rd_done_count", 64'(done_cnt), 64'd1);
    check("rd_protocol", 64'(bad), 64'd0);
    if (mode == 0 && len > 0) check("rd_first_latency", 64'(first), 64'd3);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v, w0, w1;
    int bad;
    for (int i = 0; i < DEPTH; i++) begin
      v = {$urandom, $urandom};
      ram[i] = v;
      ref_mem[i] = v;
    end
    repeat (3) step();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_signal", 64'(WR_signal), 64'd0);
    check("rst_address", 64'(address), 64'd0);
    check("rst_data_write", data_write, 64'd0);
    rst = 1'b0;
    step();

    do_write(12'h001, 4, 1'b1, 1'b1);
    do_read(12'h001, 4, 0);
    do_read(12'h000, 8, 1);
    do_write(12'hFFF, 3, 1'b1, 1'b0);
    do_read(12'hFFF, 3, 0);

    // Zero-length command: done only, no RAM access.
    issue_cmd(1'b0, 12'h123, 0);
    check("len0_done", 64'(done), 64'd1);
    check("len0_cmd_ready_in_done", 64'(cmd_ready), 64'd0);
    check("len0_no_write", 64'(WR_signal), 64'd0);
    step();
    check("len0_done_clear", 64'(done), 64'd0);
    check("len0_cmd_ready_back", 64'(cmd_ready), 64'd1);

    // Reset two beats into a len=6 write.
    w0 = {$urandom, $urandom};
    w1 = {$urandom, $urandom};
    issue_cmd(1'b1, 12'h100, 6);
    wr_valid = 1'b1; wr_data = w0;
    step();
    wr_data = w1;
    step();
    check("rst_mid_wr_signal_before", 64'(WR_signal), 64'd1);
    check("rst_mid_addr_before", 64'(address), 64'h101);
    wr_valid = 1'b0;
    rst = 1'b1;
    step();
    check("rst_mid_wr_signal_after", 64'(WR_signal), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    rst = 1'b0;
    ref_mem[12'h100] = w0;
    ref_mem[12'h101] = w1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || WR_signal) bad++;
      step();
    end
    check("rst_mid_quiet", 64'(bad), 64'd0);
    do_read(12'h100, 6, 0);

    for (int t = 0; t < 30; t++) begin
      logic [AW-1:0] b;
      int l;
      b = ($urandom_range(0, 3) == 0) ? AW'(DEPTH - $urandom_range(1, 6)) : AW'($urandom);
      l = $urandom_range(0, 12);
      if ($urandom_range(0, 1) == 1) do_write(b, l, 1'($urandom_range(0, 1)), 1'b0);
      else do_read(b, l, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
